// File: rtl/cti_commit_pkg.sv
// rtl/cti_commit_pkg.sv - shared constants and types for the CTI commit RAM read side
package cti_commit_pkg;

  localparam int COMMIT_WIDTH = 4;
  localparam int CTI_DEPTH    = 16;
  localparam int CTI_INDEX    = $clog2(CTI_DEPTH);
  localparam int CTI_WIDTH    = 8;
  localparam int CTI_CNT_W    = $clog2(COMMIT_WIDTH + 1);

  typedef logic [CTI_WIDTH-1:0] ctiPkt;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/cti_ptr_inc.sv
// rtl/cti_ptr_inc.sv - combinational modulo-DEPTH pointer adder (DEPTH = 2**INDEX)
module cti_ptr_inc #(
  parameter int INDEX = 4,
  parameter int INC_W = 3
) (
  input  logic [INDEX-1:0] i_ptr,
  input  logic [INC_W-1:0] i_inc,
  output logic [INDEX-1:0] o_ptr
);

  localparam int SUM_W = (INDEX > INC_W) ? INDEX : INC_W;

  logic [SUM_W-1:0] w_sum;

  // Power-of-two depth: wrap is plain truncation of the sum.
  assign w_sum = SUM_W'(i_ptr) + SUM_W'(i_inc);
  assign o_ptr = w_sum[INDEX-1:0];

endmodule

// File: rtl/cti_commit_reader.sv
// rtl/cti_commit_reader.sv - CTI commit RAM read-side controller, FIFO order, one-entry output register
// Optional zero-bubble bypass of write-port-0 data when empty: CTI_READ_BYPASS_EN
module cti_commit_reader #(
  parameter int DEPTH        = cti_commit_pkg::CTI_DEPTH,
  parameter int INDEX        = cti_commit_pkg::CTI_INDEX,
  parameter int WIDTH        = cti_commit_pkg::CTI_WIDTH,
  parameter int COMMIT_WIDTH = cti_commit_pkg::COMMIT_WIDTH,
  parameter int CNT_W        = cti_commit_pkg::CTI_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] commitCnt_i,
  output logic [INDEX-1:0] tailPtr_o,
  output logic [INDEX:0]   freeCnt_o,
  output logic             stallCommit_o,
  output logic             overflow_o,
  output logic [INDEX-1:0] ramAddr_o,
  input  logic [WIDTH-1:0] ramData_i,
`ifdef CTI_READ_BYPASS_EN
  input  logic [WIDTH-1:0] bypData_i,
`endif
  output logic             updValid_o,
  output logic [WIDTH-1:0] updData_o,
  input  logic             updReady_i
);

  import cti_commit_pkg::*;

  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic [INDEX-1:0] r_head;
  logic [INDEX-1:0] r_tail;
  logic [INDEX:0]   r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_overflow;

  logic [INDEX:0]   w_free;
  logic [INDEX:0]   w_cnt_ext;
  logic             w_over;
  logic [CNT_W-1:0] w_accepted;
  logic             w_can_load;
  logic             w_pop;
  logic             w_byp;
  logic             w_adv;
  logic [INDEX:0]   w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [INDEX-1:0] w_head_inc;
  logic [INDEX-1:0] w_tail_inc;

  always_comb begin
    w_free     = (INDEX+1)'(DEPTH) - r_count;
    w_cnt_ext  = (INDEX+1)'(commitCnt_i);
    w_over     = w_cnt_ext > w_free;
    // When over-committed the free count is below commitCnt_i, so it fits CNT_W bits.
    w_accepted = w_over ? CNT_W'(w_free) : commitCnt_i;
    w_can_load = (r_state == OUT_EMPTY) | updReady_i;
    w_pop      = (r_count != '0) & w_can_load;
`ifdef CTI_READ_BYPASS_EN
    w_byp      = (r_count == '0) & w_can_load & (commitCnt_i != '0);
    w_data_nxt = w_byp ? bypData_i : ramData_i;
`else
    w_byp      = 1'b0;
    w_data_nxt = ramData_i;
`endif
    w_adv       = w_pop | w_byp;
    w_count_nxt = r_count + (INDEX+1)'(w_accepted) - (INDEX+1)'(w_adv);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv) begin
      w_state_nxt = OUT_FULL;
    end else if ((r_state == OUT_FULL) && updReady_i) begin
      w_state_nxt = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  cti_ptr_inc #(
    .INDEX(INDEX),
    .INC_W(1)
  ) u_head_inc (
    .i_ptr(r_head),
    .i_inc(1'b1),
    .o_ptr(w_head_inc)
  );

  cti_ptr_inc #(
    .INDEX(INDEX),
    .INC_W(CNT_W)
  ) u_tail_inc (
    .i_ptr(r_tail),
    .i_inc(w_accepted),
    .o_ptr(w_tail_inc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_adv) begin
        r_data <= w_data_nxt;
        r_head <= w_head_inc;
      end
      r_tail  <= w_tail_inc;
      r_count <= w_count_nxt;
      if (w_over) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tailPtr_o     = r_tail;
  assign freeCnt_o     = w_free;
  assign stallCommit_o = w_free < (INDEX+1)'(COMMIT_WIDTH);
  assign overflow_o    = r_overflow;
  assign ramAddr_o     = r_head;
  assign updValid_o    = (r_state == OUT_FULL);
  assign updData_o     = r_data;

endmodule
